cache_req_queue: RTL and testbench
==================================

CACHE_REQ_QUEUE -- requirements
Module: cache_req_queue

Interface
REQ-001 SHALL have parameter CL_SIZE, default 128, cache-line data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, entry count; power of two, at least 2.
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have alloc  input  1  enqueue request.
REQ-006 SHALL have addr_in  input  32  request address.
REQ-007 SHALL have data_in  input  CL_SIZE  request line data.
REQ-008 SHALL have operation_in  input  3  request opcode.
REQ-009 SHALL have src_in / dest_in  input  2 each  source and destination IDs.
REQ-010 SHALL have is_flush_in  input  1  flush-request marker.
REQ-011 SHALL have full  output  1  no free entry.
REQ-012 SHALL have count  output  log2(DEPTH)+1  occupied entries.
REQ-013 SHALL have overflow  output  1  sticky error flag: alloc was dropped.
REQ-014 SHALL have valid_out  output  1  head entry present; drives one arbitrator valid_in bit.
REQ-015 SHALL have addr_out / data_out / operation_out / src_out / dest_out / is_flush_out  outputs  32 / CL_SIZE / 3 / 2 / 2 / 1  head payload.
REQ-016 SHALL have dealloc  input  1  arbitrator grant for this queue; pops head.

Function
REQ-017 SHALL be a circular FIFO with read pointer, write pointer and count, each register wrapping modulo DEPTH (count: 0..DEPTH).
REQ-018 full SHALL be (count == DEPTH); valid_out SHALL be (count != 0) in the base configuration.
REQ-019 Head payload outputs SHALL be combinational reads of the entry at the read pointer, forced to all-zero when valid_out is 0.
REQ-020 alloc is accepted when !full or when dealloc && valid_out in the same cycle; an accepted alloc writes the entry at the write pointer and advances the write pointer.
REQ-021 A dealloc with valid_out 1 SHALL advance the read pointer; a dealloc with valid_out 0 SHALL be ignored with no state change.
REQ-022 Simultaneous accepted alloc and valid dealloc SHALL leave count unchanged; this holds at full and at count 1.
REQ-023 alloc that is not accepted SHALL be dropped with storage unchanged, and overflow SHALL be set to 1 on the following edge and remain 1 until reset.
REQ-024 Latency: an alloc accepted at edge N into an empty queue SHALL raise valid_out after edge N (base configuration).
REQ-025 Entries SHALL leave in strict allocation order; payload SHALL be returned bit-exact.

Reset
REQ-026 On rst, pointers, count and overflow SHALL go to 0 immediately, without waiting for clk.
REQ-027 During and after reset, valid_out = 0, full = 0 and all payload outputs = 0; storage contents need not be cleared.
REQ-028 Reset asserted mid-operation SHALL discard all queued entries; dealloc or alloc in that cycle SHALL have no effect.

Configuration
REQ-029 Macro CACHE_REQ_QUEUE_BYPASS_EN, when defined: with count 0 and alloc 1, valid_out SHALL be 1 and the payload outputs SHALL equal the alloc inputs in the same cycle.
REQ-030 When bypass is active and dealloc is 1 in that same cycle, the request SHALL be consumed without being written and count SHALL stay 0.
REQ-031 When bypass is active and dealloc is 0, the entry SHALL be written normally and count SHALL become 1.
REQ-032 Without the macro, there SHALL be no combinational path from any alloc-side input to valid_out or to the payload outputs.

Verification
REQ-033 Reset, then alloc addr 0x0000_1000, op 3, src 1, dest 2, no dealloc -> after the next edge: valid_out 1, addr_out 0x1000, operation_out 3, count 1.
REQ-034 DEPTH=4: 4 allocs (addr 0x10, 0x20, 0x30, 0x40), then a fifth alloc 0x50 -> full 1, 0x50 dropped, overflow 1; four deallocs return 0x10, 0x20, 0x30, 0x40 in order, then valid_out 0 with all payload outputs 0.
REQ-035 Full queue, alloc 0x60 with dealloc in the same cycle -> count stays 4, overflow unchanged, 0x60 emerges last.
REQ-036 Empty queue, dealloc pulsed for 3 cycles -> pointers and count unchanged, valid_out 0; then 6 alloc/dealloc pairs exercise pointer wrap with data in order.
REQ-037 Queue holding 3 entries, rst asserted between edges -> count 0, valid_out 0 before the next edge; with bypass defined, alloc+dealloc on empty -> same-cycle valid_out 1 and count remains 0.

Source files
------------

// File: rtl/cache_req_queue.sv
// cache_req_queue: circular request FIFO that holds cache requests and
// presents the head entry to one input of a downstream arbitrator.
// Optional feature macro: CACHE_REQ_QUEUE_BYPASS_EN (empty-queue same-cycle
// bypass of the alloc inputs to the head outputs).
module cache_req_queue #(
    parameter int CL_SIZE = 128,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc,
    input  logic [31:0]              addr_in,
    input  logic [CL_SIZE-1:0]       data_in,
    input  logic [2:0]               operation_in,
    input  logic [1:0]               src_in,
    input  logic [1:0]               dest_in,
    input  logic                     is_flush_in,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     valid_out,
    output logic [31:0]              addr_out,
    output logic [CL_SIZE-1:0]       data_out,
    output logic [2:0]               operation_out,
    output logic [1:0]               src_out,
    output logic [1:0]               dest_out,
    output logic                     is_flush_out,
    input  logic                     dealloc
);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = 32 + CL_SIZE + 3 + 2 + 2 + 1;
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;

    logic [EW-1:0] in_entry;
    logic [EW-1:0] head_entry;
    logic          bypass;
    logic          bypass_take;
    logic          pop;
    logic          accept;
    logic          push;
    logic          advance;

    assign in_entry = {addr_in, data_in, operation_in, src_in, dest_in, is_flush_in};
    assign full     = (count_q == FULL_CNT);
    assign count    = count_q;
    assign overflow = overflow_q;

`ifdef CACHE_REQ_QUEUE_BYPASS_EN
    // An empty queue forwards the incoming request straight to the head.
    assign bypass     = (count_q == '0) && alloc;
    assign valid_out  = (count_q != '0) || alloc;
    assign head_entry = bypass ? in_entry : mem_q[rd_ptr_q];
`else
    // Head comes only from storage: no alloc-side input reaches the outputs.
    assign bypass     = 1'b0;
    assign valid_out  = (count_q != '0);
    assign head_entry = mem_q[rd_ptr_q];
`endif

    assign {addr_out, data_out, operation_out, src_out, dest_out, is_flush_out} =
        valid_out ? head_entry : '0;

    // Next-state computation for pointers, occupancy and the sticky error.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can hold an old value and infer a latch.
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;

        pop         = dealloc && valid_out;
        accept      = alloc && (!full || pop);
        bypass_take = bypass && dealloc;
        push        = accept && !bypass_take;
        advance     = pop && !bypass_take;

        if (push)    wr_ptr_d = wr_ptr_q + 1'b1;
        if (advance) rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push, advance})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (alloc && !accept) overflow_d = 1'b1;
    end

    // Control state: cleared immediately by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage: written at the write pointer on every accepted, non-bypassed alloc.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; count gates visibility, so stale data never escapes.
        if (push) mem_q[wr_ptr_q] <= in_entry;
    end

endmodule

// File: tb/tb_cache_req_queue.sv
// Self-checking bench for cache_req_queue: directed scenarios followed by
// randomized traffic, checked by a queue-based reference model and scoreboard.
module tb_cache_req_queue;
    localparam int CL_SIZE = 128;
    localparam int DEPTH   = 4;
    localparam int CW      = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0]        addr;
        logic [CL_SIZE-1:0] data;
        logic [2:0]         op;
        logic [1:0]         src;
        logic [1:0]         dest;
        logic               flush;
    } req_t;

    logic clk = 1'b0;
    logic rst;
    logic alloc, dealloc;
    req_t in_r;
    logic full, overflow, valid_out;
    logic [CW-1:0] count;
    logic [31:0] addr_out;
    logic [CL_SIZE-1:0] data_out;
    logic [2:0] operation_out;
    logic [1:0] src_out, dest_out;
    logic is_flush_out;

    cache_req_queue #(.CL_SIZE(CL_SIZE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .alloc(alloc),
        .addr_in(in_r.addr), .data_in(in_r.data), .operation_in(in_r.op),
        .src_in(in_r.src), .dest_in(in_r.dest), .is_flush_in(in_r.flush),
        .full(full), .count(count), .overflow(overflow), .valid_out(valid_out),
        .addr_out(addr_out), .data_out(data_out), .operation_out(operation_out),
        .src_out(src_out), .dest_out(dest_out), .is_flush_out(is_flush_out),
        .dealloc(dealloc)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a plain queue of outstanding requests plus the sticky error.
    req_t sb[$];
    int   m_count = 0;
    bit   m_ovf   = 1'b0;

    // Expectations for the cycle currently being driven, read by the monitor.
    bit   chk_en    = 1'b0;
    bit   exp_valid, exp_full, exp_ovf, exp_pop;
    int   exp_count;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic req_t head_now();
        return {addr_out, data_out, operation_out, src_out, dest_out, is_flush_out};
    endfunction

    function automatic req_t mk(input logic [31:0] a, input logic [2:0] op,
                                input logic [1:0] s, input logic [1:0] d);
        req_t r;
        r.addr  = a;
        r.data  = {$urandom, $urandom, $urandom, $urandom};
        r.op    = op;
        r.src   = s;
        r.dest  = d;
        r.flush = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // Drive one cycle of stimulus and advance the model across the coming edge.
    task automatic drive(input bit a, input req_t r, input bit d);
        bit v, p, acc;
        @(negedge clk);
        alloc   = a;
        in_r    = r;
        dealloc = d;
        v = (m_count != 0);
`ifdef CACHE_REQ_QUEUE_BYPASS_EN
        if (m_count == 0 && a) v = 1'b1;
`endif
        p   = d && v;
        acc = a && ((m_count < DEPTH) || p);
        exp_valid = v;
        exp_full  = (m_count == DEPTH);
        exp_count = m_count;
        exp_ovf   = m_ovf;
        exp_pop   = p;
        if (acc) sb.push_back(r);
        m_count = m_count + int'(acc) - int'(p);
        if (a && !acc) m_ovf = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0);
    endtask

    // Monitor: compare status every cycle and pop the scoreboard on each grant.
    initial begin
        req_t e;
        forever begin
            @(negedge clk);
            #4;
            if (chk_en && !rst) begin
                check("valid_out", valid_out, exp_valid);
                check("full", full, exp_full);
                check("count", count, exp_count);
                check("overflow", overflow, exp_ovf);
                if (exp_pop) begin
                    if (sb.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL pop_empty: grant with no expected entry at %0t", $time);
                    end else begin
                        e = sb.pop_front();
                        check("head_payload", head_now(), e);
                    end
                end else if (!exp_valid) begin
                    check("zero_payload", head_now(), '0);
                end
            end
        end
    end

    // Reset with alloc and dealloc active; outputs must clear before any edge.
    task automatic do_reset();
        @(negedge clk);
        chk_en  = 1'b0;
        rst     = 1'b1;
        alloc   = 1'b1;
        dealloc = 1'b1;
        in_r    = mk(32'hDEAD_0000, 3'd7, 2'd3, 2'd3);
        #1;
        check("rst_async_count", count, 0);
        check("rst_async_valid", valid_out, 1'b0);
        check("rst_async_full", full, 1'b0);
        check("rst_async_ovf", overflow, 1'b0);
        @(posedge clk);
        #1;
        check("rst_edge_count", count, 0);
        @(negedge clk);
        rst     = 1'b0;
        alloc   = 1'b0;
        dealloc = 1'b0;
        in_r    = '0;
        sb.delete();
        m_count = 0;
        m_ovf   = 1'b0;
    endtask

    initial begin
        req_t r;
        bit a, d;
        rst = 1'b1; alloc = 1'b0; dealloc = 1'b0; in_r = '0;
        #1;
        check("reset_valid", valid_out, 1'b0);
        check("reset_full", full, 1'b0);
        check("reset_payload", head_now(), '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // First request becomes visible after one edge.
        r = mk(32'h0000_1000, 3'd3, 2'd1, 2'd2);
        drive(1'b1, r, 1'b0);
        @(posedge clk);
        #1;
        check("first_valid", valid_out, 1'b1);
        check("first_addr", addr_out, 32'h1000);
        check("first_op", operation_out, 3'd3);
        check("first_count", count, 1);
        drive(1'b0, '0, 1'b1);
        idle();

        // Fill, drop a fifth, drain in order.
        for (int i = 1; i <= 4; i++) drive(1'b1, mk(32'(i * 16), 3'(i), 2'(i), 2'(i)), 1'b0);
        drive(1'b1, mk(32'h50, 3'd5, 2'd0, 2'd0), 1'b0);
        @(posedge clk);
        #1;
        check("fill_full", full, 1'b1);
        check("fill_ovf", overflow, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1);
        idle();

        // Full queue with simultaneous alloc and dealloc keeps count at DEPTH.
        for (int i = 1; i <= 4; i++) drive(1'b1, mk(32'(i * 16), 3'(i), 2'(i), 2'(i)), 1'b0);
        drive(1'b1, mk(32'h60, 3'd6, 2'd2, 2'd1), 1'b1);
        @(posedge clk);
        #1;
        check("swap_full_count", count, DEPTH);
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1);
        idle();

        // Dealloc on empty is ignored; then wrap the pointers at count 1.
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1);
        drive(1'b1, mk(32'h100, 3'd1, 2'd0, 2'd1), 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b1, mk(32'h200 + 32'(i), 3'(i), 2'(i), 2'(i + 1)), 1'b1);
        drive(1'b0, '0, 1'b1);
        idle();

        // Mid-operation reset discards three queued entries and the overflow flag.
        for (int i = 0; i < 3; i++) drive(1'b1, mk(32'h300 + 32'(i), 3'd2, 2'd1, 2'd1), 1'b0);
        do_reset();
        idle();

`ifdef CACHE_REQ_QUEUE_BYPASS_EN
        // Same-cycle bypass on an empty queue, consumed without storage.
        r = mk(32'h0000_0ABC, 3'd4, 2'd2, 2'd3);
        drive(1'b1, r, 1'b1);
        #1;
        check("bypass_valid", valid_out, 1'b1);
        check("bypass_addr", addr_out, r.addr);
        @(posedge clk);
        #1;
        check("bypass_count", count, 0);
        idle();
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 99) < 60);
            d = ($urandom_range(0, 99) < 50);
            drive(a, mk($urandom, 3'($urandom), 2'($urandom), 2'($urandom)), d);
        end
        while (m_count > 0) drive(1'b0, '0, 1'b1);
        idle();
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        check("scoreboard_empty", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
